// File: rtl/bottle_bcd_counter_if.sv
// Bottle counter sensor/control/display bundle.
// master: the side that drives sensor, enable and clear and watches the digits.
// slave:  the counter itself.
interface bottle_bcd_counter_if;
   logic       sensor;
   logic       enable;
   logic       clear;
   logic [3:0] units;
   logic [3:0] tens;
   logic       box_full;
   logic       bottle_evt;

   modport master (
      output sensor, enable, clear,
      input  units, tens, box_full, bottle_evt
   );

   modport slave (
      input  sensor, enable, clear,
      output units, tens, box_full, bottle_evt
   );
endinterface

// File: rtl/bottle_bcd_counter.sv
// Bottle counter with two BCD digits for the 7-segment decoders.
// The raw presence sensor is synchronized and turned into a one-cycle bottle_evt.
// The count then advances in BCD and wraps once per box, pulsing box_full.
// Define SENSOR_DEBOUNCE_EN to build the debounce FSM (DEBOUNCE_CYCLES stable samples).
// Without it, bottle_evt comes from a plain rising-edge detect on the synchronized sensor.
module bottle_bcd_counter #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned BOX_SIZE        = 12
) (
   input  logic                clk,
   input  logic                reset,
   bottle_bcd_counter_if.slave bus
);

   // Last count value of a box, split into BCD digits.
   localparam logic [3:0] LAST_TENS  = 4'((BOX_SIZE - 1) / 10);
   localparam logic [3:0] LAST_UNITS = 4'((BOX_SIZE - 1) % 10);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
      $error("bottle_bcd_counter: DEBOUNCE_CYCLES out of range 1..255");
   end
   if (BOX_SIZE < 2 || BOX_SIZE > 99) begin : g_bad_box
      $error("bottle_bcd_counter: BOX_SIZE out of range 2..99");
   end

   logic       s_meta;
   logic       s_sync;
   logic       evt_q;
   logic [3:0] units_q;
   logic [3:0] tens_q;
   logic       box_q;

   // Two-flop synchronizer on the asynchronous sensor.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         s_meta <= bus.sensor;
         s_sync <= s_meta;
      end
   end

`ifdef SENSOR_DEBOUNCE_EN
   typedef enum logic [1:0] {
      IDLE,
      RISE_CHK,
      PRESENT,
      FALL_CHK
   } state_t;

   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES);

   state_t     state;
   logic [7:0] dcnt;

   // Debounce FSM: a level change is accepted only after DEB_LAST stable samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         dcnt  <= '0;
         evt_q <= 1'b0;
      end else begin
         evt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (s_sync) begin
                  state <= RISE_CHK;
                  dcnt  <= 8'd1;
               end
            end
            RISE_CHK: begin
               if (!s_sync) begin
                  state <= IDLE;
                  dcnt  <= '0;
               end else if (dcnt == DEB_LAST) begin
                  state <= PRESENT;
                  evt_q <= 1'b1;
               end else begin
                  dcnt <= dcnt + 8'd1;
               end
            end
            PRESENT: begin
               if (!s_sync) begin
                  state <= FALL_CHK;
                  dcnt  <= 8'd1;
               end
            end
            FALL_CHK: begin
               if (s_sync) begin
                  state <= PRESENT;
               end else if (dcnt == DEB_LAST) begin
                  state <= IDLE;
                  dcnt  <= '0;
               end else begin
                  dcnt <= dcnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               dcnt  <= '0;
            end
         endcase
      end
   end
`else
   logic s_prev;
   logic s_prev2;

   // Rising-edge detect on a delayed copy of s_sync, so the event lands one edge
   // after the plain registered detect would (sensor at edge 0 -> event after edge 3).
   always_ff @(posedge clk) begin
      if (reset) begin
         s_prev  <= 1'b0;
         s_prev2 <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         s_prev  <= s_sync;
         s_prev2 <= s_prev;
         evt_q   <= s_prev & ~s_prev2;
      end
   end
`endif

   // BCD count: clear wins over an increment; the box wrap pulses box_full.
   always_ff @(posedge clk) begin
      if (reset) begin
         units_q <= '0;
         tens_q  <= '0;
         box_q   <= 1'b0;
      end else begin
         box_q <= 1'b0;
         if (bus.clear) begin
            units_q <= '0;
            tens_q  <= '0;
         end else if (evt_q && bus.enable) begin
            if (units_q == LAST_UNITS && tens_q == LAST_TENS) begin
               units_q <= '0;
               tens_q  <= '0;
               box_q   <= 1'b1;
            end else if (units_q == 4'd9) begin
               units_q <= '0;
               tens_q  <= tens_q + 4'd1;
            end else begin
               units_q <= units_q + 4'd1;
            end
         end
      end
   end

   assign bus.units      = units_q;
   assign bus.tens       = tens_q;
   assign bus.box_full   = box_q;
   assign bus.bottle_evt = evt_q;

endmodule

// File: tb/tb_bottle_bcd_counter.sv
// Directed bench for bottle_bcd_counter (DEBOUNCE_CYCLES=4, BOX_SIZE=12).
// Follows SENSOR_DEBOUNCE_EN: expected latencies and glitch cases switch with it.
module tb_bottle_bcd_counter;

`ifdef SENSOR_DEBOUNCE_EN
   localparam int EVT_T = 7;   // ticks from sensor rise until bottle_evt visible
`else
   localparam int EVT_T = 4;
`endif

   logic clk;
   logic reset;

   bottle_bcd_counter_if bus ();

   bottle_bcd_counter #(
      .DEBOUNCE_CYCLES (4),
      .BOX_SIZE        (12)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_vec;
   int         n_miss;
   int         evt_cnt;
   int         box_cnt;
   int         exp_cnt;
   logic [7:0] prev_digits;

   // Single comparison point: count it, report a mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      bcd = {4'(v / 10), 4'(v % 10)};
   endfunction

   // One clock, sampled 1 time unit after the edge; tallies pulses.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         prev_digits = {bus.tens, bus.units};
         @(posedge clk);
         #1;
         if (bus.bottle_evt === 1'b1) evt_cnt++;
         if (bus.box_full === 1'b1) begin
            box_cnt++;
            check("box_from_11", 32'(prev_digits), 32'h11);
            check("box_to_00", 32'({bus.tens, bus.units}), 32'h00);
         end
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      bus.sensor = 1'b1;
      tick(hi);
      bus.sensor = 1'b0;
      tick(lo);
   endtask

   task automatic count_to(input int target);
      while (exp_cnt != target) begin
         pulse(8, 8);
         exp_cnt = (exp_cnt + 1) % 12;
      end
      check("reach", 32'({bus.tens, bus.units}), 32'(bcd(target)));
   endtask

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      evt_cnt     = 0;
      box_cnt     = 0;
      exp_cnt     = 0;
      prev_digits = '0;
      reset       = 1'b1;
      bus.sensor  = 1'b1;
      bus.enable  = 1'b1;
      bus.clear   = 1'b0;

      // Reset with sensor held high.
      tick(3);
      check("rst_units", 32'(bus.units), 32'd0);
      check("rst_tens", 32'(bus.tens), 32'd0);
      check("rst_box", 32'(bus.box_full), 32'd0);
      check("rst_evt", 32'(bus.bottle_evt), 32'd0);

      reset   = 1'b0;
      evt_cnt = 0;
      tick(EVT_T - 1);
      check("rel_no_evt_yet", 32'(bus.bottle_evt), 32'd0);
      tick();
      check("rel_evt", 32'(bus.bottle_evt), 32'd1);
      check("rel_units_pre", 32'(bus.units), 32'd0);
      tick();
      check("rel_units", 32'(bus.units), 32'd1);
      check("rel_tens", 32'(bus.tens), 32'd0);
      tick(20 - EVT_T - 1);
      check("rel_one_evt", 32'(evt_cnt), 32'd1);
      bus.sensor = 1'b0;
      tick(8);
      exp_cnt = 1;

      // Plain clear back to 00.
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("clear_idle", 32'({bus.tens, bus.units}), 32'h00);
      exp_cnt = 0;

      // Full box: 01..09,10,11,00 with one box_full.
      evt_cnt = 0;
      box_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         pulse(8, 8);
         exp_cnt = (exp_cnt + 1) % 12;
         check($sformatf("wrap_step%0d", i), 32'({bus.tens, bus.units}), 32'(bcd(exp_cnt)));
      end
      check("wrap_evts", 32'(evt_cnt), 32'd12);
      check("wrap_box", 32'(box_cnt), 32'd1);

`ifdef SENSOR_DEBOUNCE_EN
      // Short glitch is filtered; dropout while present is not a new bottle.
      evt_cnt = 0;
      pulse(3, 10);
      check("glitch_evt", 32'(evt_cnt), 32'd0);
      check("glitch_digits", 32'({bus.tens, bus.units}), 32'h00);
      bus.sensor = 1'b1;
      tick(5);
      bus.sensor = 1'b0;
      tick(2);
      bus.sensor = 1'b1;
      tick(5);
      bus.sensor = 1'b0;
      tick(10);
      check("dropout_evt", 32'(evt_cnt), 32'd1);
      exp_cnt = 1;
      check("dropout_digits", 32'({bus.tens, bus.units}), 32'h01);
`else
      // Single-cycle pulse counts; two pulses one low cycle apart count twice.
      evt_cnt    = 0;
      bus.sensor = 1'b1;
      tick();
      bus.sensor = 1'b0;
      tick(2);
      check("p1_no_evt_yet", 32'(bus.bottle_evt), 32'd0);
      tick();
      check("p1_evt", 32'(bus.bottle_evt), 32'd1);
      check("p1_units_pre", 32'(bus.units), 32'd0);
      tick();
      check("p1_evt_drop", 32'(bus.bottle_evt), 32'd0);
      check("p1_units", 32'(bus.units), 32'd1);
      tick(5);
      bus.sensor = 1'b1;
      tick();
      bus.sensor = 1'b0;
      tick();
      bus.sensor = 1'b1;
      tick();
      bus.sensor = 1'b0;
      tick(8);
      check("p2_evts", 32'(evt_cnt), 32'd3);
      exp_cnt = 3;
      check("p2_digits", 32'({bus.tens, bus.units}), 32'h03);
`endif

      // Clear collides with the increment at 07: event lost.
      count_to(7);
      box_cnt    = 0;
      bus.sensor = 1'b1;
      tick(EVT_T);
      check("clr_evt", 32'(bus.bottle_evt), 32'd1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("clr_digits", 32'({bus.tens, bus.units}), 32'h00);
      check("clr_box", 32'(bus.box_full), 32'd0);
      tick(8 - EVT_T - 1);
      bus.sensor = 1'b0;
      tick(8);
      check("clr_hold", 32'({bus.tens, bus.units}), 32'h00);
      exp_cnt = 0;
      pulse(8, 8);
      exp_cnt = 1;
      check("clr_next", 32'({bus.tens, bus.units}), 32'h01);
      check("clr_no_box", 32'(box_cnt), 32'd0);

      // Disabled events are dropped but still pulse bottle_evt.
      count_to(5);
      evt_cnt    = 0;
      bus.enable = 1'b0;
      for (int i = 0; i < 3; i++) pulse(8, 8);
      check("dis_evts", 32'(evt_cnt), 32'd3);
      check("dis_digits", 32'({bus.tens, bus.units}), 32'h05);
      bus.enable = 1'b1;
      pulse(8, 8);
      check("en_digits", 32'({bus.tens, bus.units}), 32'h06);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
